// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour type, default 640x480@60 timing and channel helpers for vga_scanout
// Default build leaves VGA_TESTPAT_EN undefined; bar_colour() is only used when it is defined.
package vga_pkg;

  typedef logic [5:0] colour_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vflags_t;

  localparam vflags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_RES_SHIFT = 2;
  localparam int DEF_RD_LAT    = 1;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic logic [1:0] red(input colour_t c);
    return c[5:4];
  endfunction

  function automatic logic [1:0] grn(input colour_t c);
    return c[3:2];
  endfunction

  function automatic logic [1:0] blu(input colour_t c);
    return c[1:0];
  endfunction

  // Bar i shows each 1-bit index value doubled into both bits of its channel.
  function automatic colour_t bar_colour(input logic [9:0] h, input int bar_w);
    logic [2:0] idx;
    idx = 3'(h / 10'(bar_w));
    return {{2{idx[2]}}, {2{idx[1]}}, {2{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel divider, h/v raster counters, stage-0 sync/active flags and frame_start
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output vflags_t    flags,
  output logic       frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          h_wrap;
  logic          v_wrap;

  // Gating with resetn keeps the strobe quiet while reset is held, even with CLK_DIV=1.
  assign tick        = resetn && (div == DIV_LAST);
  assign h_wrap      = (h_cnt == H_LAST);
  assign v_wrap      = (v_cnt == V_LAST);
  assign frame_start = tick && h_wrap && v_wrap;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (tick) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign flags.active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign flags.hs     = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign flags.vs     = !((v_cnt >= V_SS) && (v_cnt < V_SE));

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - framebuffer scanout: address stage, flag delay line aligned to RAM latency, VGA output register
// Colour-bar test source is built only when VGA_TESTPAT_EN is defined.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int RES_SHIFT = DEF_RES_SHIFT,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [8:0] rd_x,
  output logic [8:0] rd_y,
  input  logic [5:0] rd_data,
  input  logic       test_mode,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam logic [8:0] X_CLAMP = 9'((H_ACTIVE - 1) >> RES_SHIFT);
  localparam logic [8:0] Y_CLAMP = 9'((V_ACTIVE - 1) >> RES_SHIFT);

  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  vflags_t    flags0;
  vflags_t    flag_dl [RD_LAT+1];
  colour_t    pix_col;
  colour_t    rgb_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .resetn      (resetn),
    .tick        (tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .flags       (flags0),
    .frame_start (frame_start)
  );

  assign pix_tick = tick;

  // Blanked positions park the address on the last visible pixel so reads stay in range.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_x <= '0;
      rd_y <= '0;
    end else if (tick) begin
      if (flags0.active) begin
        rd_x <= 9'(h_cnt >> RES_SHIFT);
        rd_y <= 9'(v_cnt >> RES_SHIFT);
      end else begin
        rd_x <= X_CLAMP;
        rd_y <= Y_CLAMP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i <= RD_LAT; i++) flag_dl[i] <= FLAGS_IDLE;
    end else if (tick) begin
      flag_dl[0] <= flags0;
      for (int i = 1; i <= RD_LAT; i++) flag_dl[i] <= flag_dl[i-1];
    end
  end

`ifdef VGA_TESTPAT_EN
  logic    bars_on;
  logic    bar_on_dl [RD_LAT+1];
  colour_t bar_dl    [RD_LAT+1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bars_on <= 1'b0;
    end else if (frame_start) begin
      bars_on <= test_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        bar_on_dl[i] <= 1'b0;
        bar_dl[i]    <= '0;
      end
    end else if (tick) begin
      bar_on_dl[0] <= bars_on;
      bar_dl[0]    <= bar_colour(h_cnt, H_ACTIVE / 8);
      for (int i = 1; i <= RD_LAT; i++) begin
        bar_on_dl[i] <= bar_on_dl[i-1];
        bar_dl[i]    <= bar_dl[i-1];
      end
    end
  end

  assign pix_col = bar_on_dl[RD_LAT] ? bar_dl[RD_LAT] : rd_data;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_col          = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else if (tick) begin
      hs_q    <= flag_dl[RD_LAT].hs;
      vs_q    <= flag_dl[RD_LAT].vs;
      blank_q <= flag_dl[RD_LAT].active;
      rgb_q   <= flag_dl[RD_LAT].active ? pix_col : '0;
    end
  end

  assign vga_r       = red(rgb_q);
  assign vga_g       = grn(rgb_q);
  assign vga_b       = blu(rgb_q);
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout on a shrunken 16x8 raster (24x12 total)
// dut_a: CLK_DIV=2 RD_LAT=1; dut_b: CLK_DIV=1 RD_LAT=3; both fed by tick-driven RAM models.
module tb_vga_scanout;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = 24, FRAME = 288, NREC = 2 * FRAME;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn    = 1'b0;
  logic test_mode = 1'b0;
  logic ram_ones  = 1'b0;

  logic [8:0] rd_x_a, rd_y_a, rd_x_b, rd_y_b;
  logic [5:0] rd_data_a, rd_data_b;
  logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, bl_a, tick_a, fs_a;
  logic       hs_b, vs_b, bl_b, tick_b, fs_b;
  logic [5:0] ram_b [3];

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(2), .RES_SHIFT(2), .RD_LAT(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_data(rd_data_a),
    .test_mode(test_mode), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a),
    .vga_vs(vs_a), .vga_blank_n(bl_a), .pix_tick(tick_a), .frame_start(fs_a)
  );

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(1), .RES_SHIFT(2), .RD_LAT(3)
  ) dut_b (
    .clk(clk), .resetn(resetn), .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_data(rd_data_b),
    .test_mode(test_mode), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b),
    .vga_vs(vs_b), .vga_blank_n(bl_b), .pix_tick(tick_b), .frame_start(fs_b)
  );

  function automatic logic [5:0] ram_word(input logic [8:0] x, input logic [8:0] y);
    return ram_ones ? 6'h3f : {y[2:0], x[2:0]};
  endfunction

  always @(posedge clk) if (tick_a) rd_data_a <= ram_word(rd_x_a, rd_y_a);

  always @(posedge clk) begin
    if (tick_b) begin
      ram_b[0] <= ram_word(rd_x_b, rd_y_b);
      ram_b[1] <= ram_b[0];
      ram_b[2] <= ram_b[1];
    end
  end
  assign rd_data_b = ram_b[2];

  int total = 0;
  int bad   = 0;
  int na, nb, ci;
  int first_tick_a, first_tick_b, fall_a, fall_b;
  int fs_cnt_a, fs_first_a, fs_last_a, idle_bad_a, idle_bad_b;
  logic [8:0] obs_a [NREC];
  logic [8:0] obs_b [NREC];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rgb_of(input logic [8:0] v);
    return int'(v[5:0]);
  endfunction

  // Sample at negedge: a tick-cycle sample shows the output of the previous tick edge,
  // i.e. raster position n-(RD_LAT+2).
  task automatic sample();
    int q;
    if (tick_a) begin
      if (first_tick_a < 0) first_tick_a = ci;
      if (fs_a) begin
        if (fs_first_a < 0) fs_first_a = na;
        fs_last_a = na;
        fs_cnt_a++;
      end
      if (!hs_a && fall_a < 0) fall_a = na;
      q = na - 3;
      if (q < 0) begin
        if ({hs_a, vs_a, bl_a, r_a, g_a, b_a} !== 9'b110_000000) idle_bad_a++;
      end else if (q < NREC) obs_a[q] = {hs_a, vs_a, bl_a, r_a, g_a, b_a};
      na++;
    end
    if (tick_b) begin
      if (first_tick_b < 0) first_tick_b = ci;
      if (!hs_b && fall_b < 0) fall_b = nb;
      q = nb - 5;
      if (q < 0) begin
        if ({hs_b, vs_b, bl_b, r_b, g_b, b_b} !== 9'b110_000000) idle_bad_b++;
      end else if (q < NREC) obs_b[q] = {hs_b, vs_b, bl_b, r_b, g_b, b_b};
      nb++;
    end
    ci++;
  endtask

  task automatic run_clks(input int n);
    repeat (n) begin
      sample();
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    @(negedge clk);
    chk({tag, "_tick_a"}, int'(tick_a), 0);
    chk({tag, "_tick_b"}, int'(tick_b), 0);
    chk({tag, "_fs_a"}, int'(fs_a), 0);
    chk({tag, "_out_a"}, int'({hs_a, vs_a, bl_a, r_a, g_a, b_a}), 9'b110_000000);
    chk({tag, "_rdxy_a"}, int'({rd_x_a, rd_y_a}), 0);
    na = 0; nb = 0; ci = 0;
    first_tick_a = -1; first_tick_b = -1; fall_a = -1; fall_b = -1;
    fs_cnt_a = 0; fs_first_a = -1; fs_last_a = -1; idle_bad_a = 0; idle_bad_b = 0;
    for (int i = 0; i < NREC; i++) begin
      obs_a[i] = '0;
      obs_b[i] = '0;
    end
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int cnt, cnt2, cnt3, f0, f1, g;

    // Colour image = {rd_y[2:0], rd_x[2:0]}, two frames.
    do_reset("rst0");
    run_clks(2 * NREC + 20);
    chk("first_tick_a", first_tick_a, 1);
    chk("first_tick_b", first_tick_b, 0);
    chk("prefill_a", idle_bad_a, 0);
    chk("prefill_b", idle_bad_b, 0);
    chk("pix0_a", int'(obs_a[0]), 9'b111_000000);
    chk("pix4_rgb", rgb_of(obs_a[4]), 1);
    chk("pix7_rgb", rgb_of(obs_a[7]), 1);
    chk("pix8_rgb", rgb_of(obs_a[8]), 2);
    chk("pix15_rgb", rgb_of(obs_a[15]), 3);
    chk("pix16_blank", int'(obs_a[16]), 9'b110_000000);
    chk("v3h8_rgb", rgb_of(obs_a[3*HT+8]), 2);
    chk("v4h8_rgb", rgb_of(obs_a[4*HT+8]), 10);
    chk("v7h15_rgb", rgb_of(obs_a[7*HT+15]), 11);
    chk("v8_blank", int'(obs_a[8*HT][6]), 0);
    chk("hs17", int'(obs_a[17][8]), 1);
    chk("hs18", int'(obs_a[18][8]), 0);
    chk("hs21", int'(obs_a[21][8]), 1);
    chk("fall_tick_a", fall_a, 21);
    chk("fall_tick_b", fall_b, 23);

    cnt = 0; cnt2 = 0; f0 = -1; f1 = -1;
    for (int q = 1; q < NREC; q++) begin
      if (obs_a[q-1][8] && !obs_a[q][8]) begin
        cnt++;
        if (f0 < 0) f0 = q;
        else if (f1 < 0) f1 = q;
      end
    end
    chk("hs_falls", cnt, 24);
    chk("hs_period", f1 - f0, 24);
    cnt = 0; cnt3 = -1;
    for (int q = 0; q < HT; q++) if (!obs_a[q][8]) cnt++;
    chk("hs_width", cnt, 3);
    cnt = 0;
    for (int q = 0; q < FRAME; q++) begin
      if (!obs_a[q][7]) begin
        cnt++;
        if (cnt3 < 0) cnt3 = q;
      end
    end
    chk("vs_width", cnt, 2 * HT);
    chk("vs_start", cnt3, 9 * HT);
    chk("fs_first", fs_first_a, FRAME - 1);
    chk("fs_period", fs_last_a - fs_first_a, FRAME);
    chk("fs_count", fs_cnt_a, 2);
    cnt = 0;
    for (int q = 1; q < HA; q++) if (obs_a[q][5:0] != obs_a[q-1][5:0]) cnt++;
    chk("line_steps", cnt, 3);
    cnt = 0; cnt2 = 0;
    for (int q = 0; q < FRAME; q++) begin
      if (obs_a[q] !== obs_a[q+FRAME]) cnt++;
      if (obs_b[q] !== obs_a[q]) cnt2++;
    end
    chk("frame_repeat", cnt, 0);
    chk("lat3_same_image", cnt2, 0);

    // All-ones RAM: colour must vanish wherever blank_n is low.
    ram_ones = 1'b1;
    do_reset("rst1");
    run_clks(620);
    cnt = 0; cnt2 = 0; cnt3 = 0; g = 0;
    for (int q = 0; q < FRAME; q++) begin
      if (!obs_a[q][6] && obs_a[q][5:0] != 6'd0) cnt++;
      if (obs_a[q][6] && obs_a[q][5:0] == 6'h3f) cnt2++;
      if (!obs_a[q][6]) cnt3++;
      if (!obs_b[q][6] && obs_b[q][5:0] != 6'd0) g++;
    end
    chk("ones_blank_rgb_a", cnt, 0);
    chk("ones_visible", cnt2, HA * VA);
    chk("ones_blank_cnt", cnt3, FRAME - HA * VA);
    chk("ones_blank_rgb_b", g, 0);

    // Mid-frame reset near h=10, v=5.
    ram_ones = 1'b0;
    do_reset("rst2");
    g = 0;
    while (na < 5 * HT + 10 && g < 1000) begin
      sample();
      @(negedge clk);
      g++;
    end
    chk("mid_reach", na, 5 * HT + 10);
    chk("mid_rd_x", int'(rd_x_a), 2);
    chk("mid_rd_y", int'(rd_y_a), 1);
    do_reset("rst3");
    run_clks(100);
    chk("re_first_tick_a", first_tick_a, 1);
    chk("re_prefill_a", idle_bad_a, 0);
    chk("re_prefill_b", idle_bad_b, 0);
    chk("re_pix0", int'(obs_a[0]), 9'b111_000000);
    chk("re_pix5_rgb", rgb_of(obs_a[5]), 1);
    chk("re_v1h4_rgb", rgb_of(obs_a[HT+4]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
